// File: rtl/ubus_arb_pkg.sv
// ubus_arb_pkg: shared types for the UBUS arbiter family.
// Phase-state encoding and arbitration-mode constants.
package ubus_arb_pkg;

  // 3-bit encoding kept stable so existing waveform decoders still work.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_START = 3'd3,
    ST_NOP   = 3'd4
  } ubus_state_e;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/ubus_rr_pick.sv
// ubus_rr_pick: combinational fixed-priority / round-robin picker.
// in: i_req, i_ptr (last winner), i_mode; out: one-hot o_gnt, o_idx.
module ubus_rr_pick
  import ubus_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  input  logic                 i_mode,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_k;
  logic          w_hit;

  // Candidate index at search offset off, starting just past the pointer.
  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] p,
    input int            off
  );
    int s;
    s = int'(p) + 1 + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    w_k   = '0;
    for (int i = 0; i < N; i++) begin
      w_k = (i_mode == ARB_RR) ? rot(i_ptr, i) : IW'(i);
      if (!w_hit && i_req[w_k]) begin
        w_hit     = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx     = w_k;
      end
    end
  end

endmodule

// File: rtl/ubus_arbiter_n.sv
// ubus_arbiter_n: N-master UBUS arbiter + phase sequencer with wait timeout.
// in: clock, reset_n, req, bip, wait, error; out: gnt, start, read, write, gnt_id, timeout.
module ubus_arbiter_n
  import ubus_arb_pkg::*;
#(
  parameter int NUM_MASTERS  = 4,
  parameter int ARB_MODE     = 0,
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic                           ubus_clock,
  input  logic                           ubus_reset_n,
  input  logic [NUM_MASTERS-1:0]         ubus_req,
  output logic [NUM_MASTERS-1:0]         ubus_gnt,
  output logic                           ubus_start,
  output wire                            ubus_read,
  output wire                            ubus_write,
  input  logic                           ubus_bip,
  input  logic                           ubus_wait,
  input  logic                           ubus_error,
  output logic [$clog2(NUM_MASTERS)-1:0] gnt_id,
  output logic                           timeout
);

  localparam int IW = $clog2(NUM_MASTERS);

  localparam logic L_MODE =
    (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;
  localparam logic L_TO_EN = (WAIT_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] L_TO_LAST =
    CNT_W'(WAIT_TIMEOUT - 1);

  ubus_state_e r_state;
  ubus_state_e w_state_nxt;

  logic                   r_start;
  logic                   w_start_nxt;
  logic                   r_timeout;
  logic                   w_to_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_noop;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [IW-1:0]          r_gnt_id;
  logic [IW-1:0]          r_ptr;

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [IW-1:0]          w_pick_idx;

  ubus_rr_pick #(
    .N (NUM_MASTERS)
  ) u_pick (
    .i_req  (ubus_req),
    .i_ptr  (r_ptr),
    .i_mode (L_MODE),
    .o_gnt  (w_pick_gnt),
    .o_idx  (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_start_nxt = 1'b1;
        w_state_nxt = ST_START;
      end
      ST_START: begin
        w_state_nxt =
          (r_gnt == '0) ? ST_NOP : ST_ADDR;
      end
      ST_NOP: begin
        w_start_nxt = 1'b1;
        w_state_nxt = ST_START;
      end
      ST_ADDR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        // error beats completion beats timeout
        if (ubus_error ||
            (!ubus_bip && !ubus_wait)) begin
          w_start_nxt = 1'b1;
          w_state_nxt = ST_START;
        end else if (ubus_wait && L_TO_EN &&
                     r_cnt == L_TO_LAST) begin
          w_start_nxt = 1'b1;
          w_to_nxt    = 1'b1;
          w_state_nxt = ST_START;
        end else if (ubus_wait) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge ubus_clock or negedge ubus_reset_n) begin
    if (!ubus_reset_n) begin
      r_state   <= ST_INIT;
      r_start   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_noop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start   <= w_start_nxt;
      r_timeout <= w_to_nxt;
      r_cnt     <= w_cnt_nxt;
      r_noop    <= r_start && (r_gnt == '0);
    end
  end

  // Grants launch on the falling edge so the phase FSM sees them
  // on the very next rising edge; each grant lives one period.
  always_ff @(negedge ubus_clock or negedge ubus_reset_n) begin
    if (!ubus_reset_n) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_ptr    <= IW'(NUM_MASTERS - 1);
    end else if (r_start && (|ubus_req)) begin
      r_gnt    <= w_pick_gnt;
      r_gnt_id <= w_pick_idx;
      r_ptr    <= w_pick_idx;
    end else begin
      r_gnt    <= '0;
    end
  end

  assign ubus_gnt   = r_gnt;
  assign ubus_start = r_start;
  assign gnt_id     = r_gnt_id;
  assign timeout    = r_timeout;
  assign ubus_read  = r_noop ? 1'b0 : 1'bz;
  assign ubus_write = r_noop ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ubus_arbiter_n.sv
// tb_ubus_arbiter_n: directed bench for ubus_arbiter_n.
// Fixed-mode and round-robin instances share clock, reset and slave inputs.
module tb_ubus_arbiter_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_f;
  logic [3:0] req_r;
  logic       bip;
  logic       wt;
  logic       err;

  logic [3:0] gnt_f;
  logic [3:0] gnt_r;
  logic       start_f;
  logic       start_r;
  wire        rd_f;
  wire        wr_f;
  wire        rd_r;
  wire        wr_r;
  logic [1:0] id_f;
  logic [1:0] id_r;
  logic       to_f;
  logic       to_r;

  int n_vec;
  int n_err;

  ubus_arbiter_n #(
    .NUM_MASTERS  (4),
    .ARB_MODE     (0),
    .WAIT_TIMEOUT (16),
    .CNT_W        (5)
  ) u_fix (
    .ubus_clock   (clk),
    .ubus_reset_n (rst_n),
    .ubus_req     (req_f),
    .ubus_gnt     (gnt_f),
    .ubus_start   (start_f),
    .ubus_read    (rd_f),
    .ubus_write   (wr_f),
    .ubus_bip     (bip),
    .ubus_wait    (wt),
    .ubus_error   (err),
    .gnt_id       (id_f),
    .timeout      (to_f)
  );

  ubus_arbiter_n #(
    .NUM_MASTERS  (4),
    .ARB_MODE     (1),
    .WAIT_TIMEOUT (16),
    .CNT_W        (5)
  ) u_rr (
    .ubus_clock   (clk),
    .ubus_reset_n (rst_n),
    .ubus_req     (req_r),
    .ubus_gnt     (gnt_r),
    .ubus_start   (start_r),
    .ubus_read    (rd_r),
    .ubus_write   (wr_r),
    .ubus_bip     (bip),
    .ubus_wait    (wt),
    .ubus_error   (err),
    .gnt_id       (id_r),
    .timeout      (to_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  // Advance to a rising edge where the chosen instance shows start=1.
  task automatic sync(input bit rr);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!ok) begin
        @(posedge clk); #1;
        if ((rr ? start_r : start_f) === 1'b1)
          ok = 1'b1;
      end
    end
    chk("sync", 32'(ok), 32'd1);
  endtask

  // One zero-wait transfer; entered and left just after a start edge.
  task automatic xfer(
    input bit         rr,
    input logic [3:0] rq,
    input logic [3:0] mid,
    input logic [3:0] eg,
    input logic [1:0] eid
  );
    if (rr) req_r = rq; else req_f = rq;
    @(negedge clk); #1;
    chk("gnt", 32'(rr ? gnt_r : gnt_f), 32'(eg));
    chk("gnt_id", 32'(rr ? id_r : id_f), 32'(eid));
    @(posedge clk); #1;
    chk("addr_start",
        32'(rr ? start_r : start_f), 32'd0);
    if (rr) req_r = mid; else req_f = mid;
    @(negedge clk); #1;
    chk("gnt_drop", 32'(rr ? gnt_r : gnt_f), 32'd0);
    chk("id_hold", 32'(rr ? id_r : id_f), 32'(eid));
    @(posedge clk); #1;
    chk("data_start",
        32'(rr ? start_r : start_f), 32'd0);
    @(posedge clk); #1;
    chk("done_start",
        32'(rr ? start_r : start_f), 32'd1);
  endtask

  // Data phase on the fixed instance with a held wait.
  task automatic dp(
    input int   pre,
    input logic lw,
    input logic le,
    input logic eto
  );
    sync(1'b0);
    req_f = 4'b0001;
    wt    = 1'b1;
    bip   = 1'b0;
    err   = 1'b0;
    @(negedge clk); #1;
    chk("dp_gnt", 32'(gnt_f), 32'h1);
    req_f = 4'b0000;
    @(posedge clk); #1;
    chk("dp_addr", 32'({start_f, to_f}), 32'd0);
    @(posedge clk); #1;
    chk("dp_data", 32'({start_f, to_f}), 32'd0);
    for (int i = 0; i < pre; i++) begin
      @(posedge clk); #1;
      chk("dp_pre", 32'({start_f, to_f}), 32'd0);
    end
    if (pre > 0) begin
      wt  = 1'b0;
      bip = 1'b1;
      @(posedge clk); #1;
      chk("dp_bip", 32'({start_f, to_f}), 32'd0);
      wt  = 1'b1;
      bip = 1'b0;
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("dp_wait", 32'({start_f, to_f}), 32'd0);
    end
    wt  = lw;
    err = le;
    @(posedge clk); #1;
    chk("dp_end_start", 32'(start_f), 32'd1);
    chk("dp_end_to", 32'(to_f), 32'(eto));
    wt  = 1'b0;
    err = 1'b0;
    @(posedge clk); #1;
    chk("dp_to_pulse", 32'({start_f, to_f}), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_f = '0;
    req_r = '0;
    bip   = 1'b0;
    wt    = 1'b0;
    err   = 1'b0;
    #2;
    chk("rst_start", 32'({start_f, start_r}), 32'd0);
    chk("rst_gnt", 32'({gnt_f, gnt_r}), 32'd0);
    chk("rst_id", 32'({id_f, id_r}), 32'd0);
    chk("rst_to", 32'({to_f, to_r}), 32'd0);
    #10 rst_n = 1'b1;

    @(posedge clk); #1;
    chk("init_start", 32'({start_f, start_r}), 32'd3);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("idle_start", 32'({start_f, start_r}),
          (k % 2) ? 32'd0 : 32'd3);
      if (k % 2) begin
        chk("noop_rw",
            32'({rd_f, wr_f, rd_r, wr_r}), 32'd0);
        chk("idle_gnt", 32'({gnt_f, gnt_r}), 32'd0);
      end
    end

    sync(1'b0);
    xfer(1'b0, 4'b1010, 4'b1111, 4'b0010, 2'd1);
    xfer(1'b0, 4'b1010, 4'b1000, 4'b0010, 2'd1);
    xfer(1'b0, 4'b1100, 4'b1100, 4'b0100, 2'd2);
    xfer(1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3);

    dp(0, 1'b1, 1'b0, 1'b1);
    dp(0, 1'b0, 1'b0, 1'b0);
    dp(0, 1'b1, 1'b1, 1'b0);
    dp(8, 1'b1, 1'b0, 1'b1);

    sync(1'b1);
    xfer(1'b1, 4'b1111, 4'b1111, 4'b0001, 2'd0);
    xfer(1'b1, 4'b1111, 4'b1111, 4'b0010, 2'd1);
    xfer(1'b1, 4'b1111, 4'b1111, 4'b0100, 2'd2);
    xfer(1'b1, 4'b1111, 4'b1111, 4'b1000, 2'd3);
    xfer(1'b1, 4'b1111, 4'b1010, 4'b0001, 2'd0);
    xfer(1'b1, 4'b1010, 4'b1010, 4'b0010, 2'd1);
    xfer(1'b1, 4'b1010, 4'b1010, 4'b1000, 2'd3);
    xfer(1'b1, 4'b1010, 4'b0000, 4'b0010, 2'd1);

    sync(1'b0);
    req_f = 4'b0100;
    wt    = 1'b1;
    @(negedge clk); #1;
    chk("ar_gnt", 32'(gnt_f), 32'h4);
    chk("ar_id", 32'(id_f), 32'd2);
    req_f = 4'b0000;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_start", 32'({start_f, start_r}), 32'd0);
    chk("ar_gnt0", 32'({gnt_f, gnt_r}), 32'd0);
    chk("ar_id0", 32'({id_f, id_r}), 32'd0);
    chk("ar_to", 32'({to_f, to_r}), 32'd0);
    wt = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("ar_hold", 32'({start_f, start_r}), 32'd0);
    @(posedge clk); #1;
    chk("ar_restart", 32'({start_f, start_r}), 32'd3);
    @(negedge clk); #1;
    chk("ar_idle_gnt", 32'({gnt_f, gnt_r}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
